// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit adder. One 4-bit carry-lookahead slice
// is reused for every nibble, LSB nibble first. The carry between nibbles is
// held in a register.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                synchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   out_valid / out_ready result handshake (sum, cout[, ovf])
//   sum                  a + b + cin, low WIDTH bits
//   cout                 carry out of bit WIDTH-1
//   ovf                  signed overflow; present only when CLA_SEQ_OVF_EN is defined
//
// Optional feature macro: CLA_SEQ_OVF_EN (adds the ovf output).
// Timing: an accept at edge T gives out_valid from edge T+NIB. One operation
// completes every NIB+2 cycles when out_ready is held high.

module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Every carry is computed directly from g/p and c_i, so no carry ripples.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic             carry_q, cout_q, out_valid_q;
  logic [CW-1:0]    nib_cnt_q;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_sh_d;
  logic             last_nib;

  cla4 u_slice (
    .a_i (a_sh_q[3:0]),
    .b_i (b_sh_q[3:0]),
    .c_i (carry_q),
    .s_o (slice_sum),
    .c_o (slice_cout)
  );

  // The new nibble enters at the top. After NIB shifts, the first nibble has
  // reached bit 0. The cast avoids a zero-width replication when WIDTH == 4.
  assign sum_sh_d = (sum_sh_q >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));
  assign last_nib = (nib_cnt_q == CW'(NIB - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CLA_SEQ_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      nib_cnt_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q    <= a;
            b_sh_q    <= b;
            carry_q   <= cin;
            nib_cnt_q <= '0;
`ifdef CLA_SEQ_OVF_EN
            // The operand shifters lose the MSBs, so keep them for the overflow test.
            a_msb_q   <= a[WIDTH-1];
            b_msb_q   <= b[WIDTH-1];
`endif
            state_q   <= RUN;
          end
        end
        RUN: begin
          a_sh_q    <= a_sh_q >> 4;
          b_sh_q    <= b_sh_q >> 4;
          sum_sh_q  <= sum_sh_d;
          carry_q   <= slice_cout;
          nib_cnt_q <= nib_cnt_q + CW'(1);
          if (last_nib) begin
            // The result registers load here and then hold through DONE and IDLE.
            sum_q       <= sum_sh_d;
            cout_q      <= slice_cout;
            out_valid_q <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
            ovf_q       <= (a_msb_q == b_msb_q) && (sum_sh_d[WIDTH-1] != a_msb_q);
`endif
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
